// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory.
// Port 0 is the processor data path, port 1 the host/loader port. One
// transaction is in flight at a time; simultaneous requests alternate
// round-robin. All outputs are registered so they reset to zero at once.
module mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int READ_LAT = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, state_d;
  logic          last, last_d;       // port served most recently
  logic          win, win_d;         // port owning the current transaction
  logic          pick;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    cnt, cnt_d;         // cycles left until mem_rdata is valid
  logic          gnt0_d, gnt1_d, rv0_d, rv1_d, en_d, mwe_d;
  logic [DW-1:0] rdata0_d, rdata1_d;

  // The command bus is held from the latched request; only mem_en/mem_we
  // qualify it, so address and data may be stale outside ISSUE.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Next-state and next-output logic; requests are only looked at in IDLE.
  always_comb begin
    state_d  = state;
    last_d   = last;
    win_d    = win;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    en_d     = 1'b0;
    mwe_d    = 1'b0;
    rdata0_d = p0_rdata;
    rdata1_d = p1_rdata;
    // On a tie the port that was not served last wins.
    pick     = (p0_req && p1_req) ? ~last : p1_req;
    case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          win_d   = pick;
          last_d  = pick;
          we_d    = pick ? p1_we    : p0_we;
          addr_d  = pick ? p1_addr  : p0_addr;
          wdata_d = pick ? p1_wdata : p0_wdata;
          en_d    = 1'b1;
          mwe_d   = we_d;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = 3'(READ_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt - 3'd1;
        // cnt reaches 1 in the cycle READ_LAT after ISSUE, when data is valid.
        if (cnt == 3'd1) begin
          state_d = IDLE;
          if (win) begin
            rv1_d    = 1'b1;
            rdata1_d = mem_rdata;
          end else begin
            rv0_d    = 1'b1;
            rdata0_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs; reset abandons any read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      last      <= 1'b1;
      win       <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      state     <= state_d;
      last      <= last_d;
      win       <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt       <= cnt_d;
      p0_gnt    <= gnt0_d;
      p1_gnt    <= gnt1_d;
      p0_rvalid <= rv0_d;
      p1_rvalid <= rv1_d;
      p0_rdata  <= rdata0_d;
      p1_rdata  <= rdata1_d;
      mem_en    <= en_d;
      mem_we    <= mwe_d;
    end
  end

endmodule
